// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
//
// Multi-cycle controller that sequences a small register file against an
// external ALU. One instruction is accepted at a time from a valid/ready
// handshake. It then runs through a short fixed state sequence:
//   ALU ops (ADD/SUB/AND/OR/XOR/NOT) : IDLE -> ISSUE -> WB -> IDLE
//   LDI / NOP                         : IDLE -> LOAD -> IDLE
//   illegal opcodes (8..15)           : IDLE -> FAULT -> IDLE
//
// Ports
//   CLK, RST                 clock; synchronous active-high reset
//   INSTR_VALID/INSTR_READY  instruction handshake (READY only in IDLE)
//   INSTR_OP/RD/RS/RT/IMM    instruction fields, latched at acceptance
//   ALU_EN, ALU_OE           ALU strobe (ISSUE only), output enable (always 1)
//   ALU_OPCODE, ALU_A/B      operands presented to the ALU
//   ALU_RESULT, ALU_CF/OF/SF/ZF  result and flags returned from the ALU
//   DONE, ERR                one-cycle completion / illegal-opcode pulses
//   WB_ADDR, WB_DATA         writeback address/data, valid while DONE=1
//   FLAGS                    architectural flags {CF,OF,SF,ZF}
//   DBG_ADDR, DBG_DATA       combinational register-file read port
// -----------------------------------------------------------------------------
module alu_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [3:0]       INSTR_OP,
    input  logic [AW-1:0]    INSTR_RD,
    input  logic [AW-1:0]    INSTR_RS,
    input  logic [AW-1:0]    INSTR_RT,
    input  logic [WIDTH-1:0] INSTR_IMM,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF,
    output logic             DONE,
    output logic             ERR,
    output logic [AW-1:0]    WB_ADDR,
    output logic [WIDTH-1:0] WB_DATA,
    output logic [3:0]       FLAGS,
    input  logic [AW-1:0]    DBG_ADDR,
    output logic [WIDTH-1:0] DBG_DATA
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WB    = 3'd2,
        ST_LOAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t           state_r;

    // Instruction fields captured at acceptance
    logic [3:0]       op_r;
    logic [AW-1:0]    rd_r;
    logic [WIDTH-1:0] imm_r;

    logic [WIDTH-1:0] regs_r [NREG];
    logic [3:0]       flags_r;

    logic             done_r;
    logic             err_r;
    logic             alu_en_r;
    logic [3:0]       alu_opcode_r;
    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [AW-1:0]    wb_addr_r;
    logic [WIDTH-1:0] wb_data_r;

    logic             ready_s;
    logic             wb_state_s;
    logic [WIDTH-1:0] wb_data_s;

    // Controller FSM, register file, flags and all registered outputs.
    // Output registers are loaded on the edge that enters a state, so each
    // pulse lines up exactly with the state it decodes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            op_r         <= 4'd0;
            rd_r         <= {AW{1'b0}};
            imm_r        <= {WIDTH{1'b0}};
            flags_r      <= 4'd0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            alu_en_r     <= 1'b0;
            alu_opcode_r <= 4'd0;
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            wb_addr_r    <= {AW{1'b0}};
            wb_data_r    <= {WIDTH{1'b0}};
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            // Pulsed outputs fall back to idle values unless a transition sets them
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            alu_en_r  <= 1'b0;
            wb_addr_r <= {AW{1'b0}};
            wb_data_r <= {WIDTH{1'b0}};

            case (state_r)
                ST_IDLE: begin
                    // READY is implied here: state is IDLE and RST is low
                    if (INSTR_VALID) begin
                        op_r  <= INSTR_OP;
                        rd_r  <= INSTR_RD;
                        imm_r <= INSTR_IMM;
                        case (INSTR_OP)
                            OP_NOP: begin
                                state_r <= ST_LOAD;
                                done_r  <= 1'b1;
                            end
                            OP_LDI: begin
                                state_r   <= ST_LOAD;
                                done_r    <= 1'b1;
                                wb_addr_r <= INSTR_RD;
                                wb_data_r <= INSTR_IMM;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                                // Operands are read here, before any writeback of
                                // this instruction, so rd aliasing rs/rt sees old data
                                state_r      <= ST_ISSUE;
                                alu_en_r     <= 1'b1;
                                alu_opcode_r <= INSTR_OP;
                                alu_a_r      <= regs_r[INSTR_RS];
                                alu_b_r      <= regs_r[INSTR_RT];
                            end
                            default: begin
                                state_r <= ST_FAULT;
                                err_r   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // ALU operands stay held so the result is stable through WB
                    state_r   <= ST_WB;
                    done_r    <= 1'b1;
                    wb_addr_r <= rd_r;
                end
                ST_WB: begin
                    state_r      <= ST_IDLE;
                    regs_r[rd_r] <= ALU_RESULT;
                    if ((op_r == OP_ADD) || (op_r == OP_SUB)) begin
                        flags_r <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
                    end else begin
                        // Logic ops leave carry and overflow untouched
                        flags_r <= {flags_r[3:2], ALU_SF, ALU_ZF};
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_IDLE;
                    if (op_r == OP_LDI) begin
                        regs_r[rd_r] <= imm_r;
                    end
                end
                ST_FAULT: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and writeback data decode; WB_DATA follows the ALU live in WB
    always_comb begin
        ready_s    = 1'b0;
        wb_state_s = 1'b0;
        wb_data_s  = wb_data_r;
        if ((state_r == ST_IDLE) && !RST) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        if (state_r == ST_WB) begin
            wb_state_s = 1'b1;
            wb_data_s  = ALU_RESULT;
        end else begin
            wb_state_s = 1'b0;
            wb_data_s  = wb_data_r;
        end
    end

    assign INSTR_READY = ready_s;
    assign ALU_EN      = alu_en_r;
    assign ALU_OE      = 1'b1;
    assign ALU_OPCODE  = alu_opcode_r;
    assign ALU_A       = alu_a_r;
    assign ALU_B       = alu_b_r;
    assign DONE        = done_r;
    assign ERR         = err_r;
    assign WB_ADDR     = wb_addr_r;
    assign WB_DATA     = wb_data_s;
    assign FLAGS       = flags_r;
    assign DBG_DATA    = regs_r[DBG_ADDR];

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl: directed self-checking bench for alu_ctrl. A behavioural ALU
// answers the controller; all expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST;
    logic             INSTR_VALID;
    logic             INSTR_READY;
    logic [3:0]       INSTR_OP;
    logic [1:0]       INSTR_RD;
    logic [1:0]       INSTR_RS;
    logic [1:0]       INSTR_RT;
    logic [WIDTH-1:0] INSTR_IMM;
    logic             ALU_EN;
    logic             ALU_OE;
    logic [3:0]       ALU_OPCODE;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH-1:0] ALU_RESULT;
    logic             ALU_CF;
    logic             ALU_OF;
    logic             ALU_SF;
    logic             ALU_ZF;
    logic             DONE;
    logic             ERR;
    logic [1:0]       WB_ADDR;
    logic [WIDTH-1:0] WB_DATA;
    logic [3:0]       FLAGS;
    logic [1:0]       DBG_ADDR;
    logic [WIDTH-1:0] DBG_DATA;

    int n_checks;
    int n_fails;

    alu_ctrl #(.WIDTH(WIDTH), .NREG(4)) dut (
        .CLK(CLK), .RST(RST),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .INSTR_OP(INSTR_OP), .INSTR_RD(INSTR_RD), .INSTR_RS(INSTR_RS),
        .INSTR_RT(INSTR_RT), .INSTR_IMM(INSTR_IMM),
        .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_RESULT(ALU_RESULT),
        .ALU_CF(ALU_CF), .ALU_OF(ALU_OF), .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF),
        .DONE(DONE), .ERR(ERR), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .FLAGS(FLAGS), .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA)
    );

    // Clock generation, 10 time-unit period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural ALU: combinational on the held operands; SUB carry is borrow
    logic [WIDTH:0] alu_sum_s;
    always_comb begin
        alu_sum_s  = {(WIDTH+1){1'b0}};
        ALU_RESULT = {WIDTH{1'b0}};
        ALU_CF     = 1'b0;
        ALU_OF     = 1'b0;
        case (ALU_OPCODE)
            4'd2: begin
                alu_sum_s  = {1'b0, ALU_A} + {1'b0, ALU_B};
                ALU_RESULT = alu_sum_s[WIDTH-1:0];
                ALU_CF     = alu_sum_s[WIDTH];
                ALU_OF     = (ALU_A[WIDTH-1] == ALU_B[WIDTH-1]) && (ALU_RESULT[WIDTH-1] != ALU_A[WIDTH-1]);
            end
            4'd3: begin
                ALU_RESULT = ALU_A - ALU_B;
                ALU_CF     = (ALU_A < ALU_B);
                ALU_OF     = (ALU_A[WIDTH-1] != ALU_B[WIDTH-1]) && (ALU_RESULT[WIDTH-1] != ALU_A[WIDTH-1]);
            end
            4'd4:    ALU_RESULT = ALU_A & ALU_B;
            4'd5:    ALU_RESULT = ALU_A | ALU_B;
            4'd6:    ALU_RESULT = ALU_A ^ ALU_B;
            4'd7:    ALU_RESULT = ~ALU_A;
            default: ALU_RESULT = {WIDTH{1'b0}};
        endcase
        ALU_SF = ALU_RESULT[WIDTH-1];
        ALU_ZF = (ALU_RESULT == {WIDTH{1'b0}});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic dbg_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        DBG_ADDR = addr;
        #1;
        check(tag, 32'(DBG_DATA), 32'(exp));
    endtask

    // Waits (bounded) for READY, offers one instruction, returns #1 after acceptance
    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [1:0] rt, input logic [7:0] imm);
        int w;
        w = 0;
        while ((INSTR_READY !== 1'b1) && (w < 10)) begin
            @(posedge CLK);
            #1;
            w++;
        end
        check("ready_before_send", 32'(INSTR_READY), 32'd1);
        INSTR_OP    = op;
        INSTR_RD    = rd;
        INSTR_RS    = rs;
        INSTR_RT    = rt;
        INSTR_IMM   = imm;
        INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        INSTR_VALID = 1'b0;
    endtask

    task automatic do_ldi(input logic [1:0] rd, input logic [7:0] imm);
        send(4'd1, rd, 2'd0, 2'd0, imm);
        check("ldi_done", 32'(DONE), 32'd1);
        check("ldi_wb_addr", 32'(WB_ADDR), 32'(rd));
        check("ldi_wb_data", 32'(WB_DATA), 32'(imm));
        @(posedge CLK);
        #1;
        dbg_check("ldi_dbg", rd, imm);
    endtask

    task automatic do_alu(input string tag, input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs, input logic [1:0] rt,
                          input logic [7:0] exp_data, input logic [3:0] exp_flags);
        send(op, rd, rs, rt, 8'h00);
        check({tag, "_issue_en"}, 32'(ALU_EN), 32'd1);
        check({tag, "_issue_op"}, 32'(ALU_OPCODE), 32'(op));
        check({tag, "_issue_done"}, 32'(DONE), 32'd0);
        @(posedge CLK);
        #1;
        check({tag, "_wb_en"}, 32'(ALU_EN), 32'd0);
        check({tag, "_wb_done"}, 32'(DONE), 32'd1);
        check({tag, "_wb_addr"}, 32'(WB_ADDR), 32'(rd));
        check({tag, "_wb_data"}, 32'(WB_DATA), 32'(exp_data));
        @(posedge CLK);
        #1;
        check({tag, "_post_done"}, 32'(DONE), 32'd0);
        check({tag, "_flags"}, 32'(FLAGS), 32'(exp_flags));
        dbg_check({tag, "_dbg"}, rd, exp_data);
    endtask

    // Back-to-back stream state
    logic [3:0] s_op [3];
    logic [1:0] s_rd [3];
    logic [1:0] s_rs [3];
    logic [1:0] s_rt [3];
    int         acc_cyc [3];
    logic [1:0] got_addr [3];
    logic [7:0] got_data [3];
    int         idx;
    int         ndone;
    int         cyc;
    logic       ready_before;

    // Directed stimulus
    initial begin
        n_checks    = 0;
        n_fails     = 0;
        RST         = 1'b1;
        INSTR_VALID = 1'b0;
        INSTR_OP    = 4'd0;
        INSTR_RD    = 2'd0;
        INSTR_RS    = 2'd0;
        INSTR_RT    = 2'd0;
        INSTR_IMM   = 8'h00;
        DBG_ADDR    = 2'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready_low", 32'(INSTR_READY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_alu_en", 32'(ALU_EN), 32'd0);
        check("rst_alu_oe", 32'(ALU_OE), 32'd1);
        check("rst_flags", 32'(FLAGS), 32'd0);
        check("rst_wb", {22'd0, WB_ADDR, WB_DATA}, 32'd0);
        RST = 1'b0;
        #1;
        check("ready_after_rst", 32'(INSTR_READY), 32'd1);
        dbg_check("rst_r3", 2'd3, 8'h00);

        // 0x7F + 0x01: signed overflow, negative result
        do_ldi(2'd1, 8'h7F);
        do_ldi(2'd2, 8'h01);
        do_alu("add_of", 4'd2, 2'd3, 2'd1, 2'd2, 8'h80, 4'b0110);

        // 0xFF + 0x01 wraps to zero with carry; AND keeps carry
        do_ldi(2'd1, 8'hFF);
        do_alu("add_cz", 4'd2, 2'd0, 2'd1, 2'd2, 8'h00, 4'b1001);
        do_alu("and", 4'd4, 2'd0, 2'd1, 2'd1, 8'hFF, 4'b1010);

        // 3 - 5 borrows
        do_ldi(2'd1, 8'h03);
        do_ldi(2'd2, 8'h05);
        do_alu("sub", 4'd3, 2'd3, 2'd1, 2'd2, 8'hFE, 4'b1010);
        do_alu("or", 4'd5, 2'd0, 2'd1, 2'd2, 8'h07, 4'b1000);
        do_alu("xor_alias", 4'd6, 2'd1, 2'd1, 2'd1, 8'h00, 4'b1001);
        do_alu("not_alias", 4'd7, 2'd2, 2'd2, 2'd0, 8'hFA, 4'b1010);

        // Illegal opcode: ERR pulse only, nothing written
        send(4'hA, 2'd0, 2'd1, 2'd2, 8'h55);
        check("ill_err", 32'(ERR), 32'd1);
        check("ill_done", 32'(DONE), 32'd0);
        check("ill_alu_en", 32'(ALU_EN), 32'd0);
        @(posedge CLK);
        #1;
        check("ill_err_clear", 32'(ERR), 32'd0);
        check("ill_ready", 32'(INSTR_READY), 32'd1);
        check("ill_flags", 32'(FLAGS), 32'b1010);
        dbg_check("ill_r0", 2'd0, 8'h07);
        dbg_check("ill_r1", 2'd1, 8'h00);
        dbg_check("ill_r2", 2'd2, 8'hFA);
        dbg_check("ill_r3", 2'd3, 8'hFE);

        // NOP completes in one cycle with zero writeback data
        send(4'd0, 2'd3, 2'd0, 2'd0, 8'h99);
        check("nop_done", 32'(DONE), 32'd1);
        check("nop_wb_data", 32'(WB_DATA), 32'd0);
        check("nop_err", 32'(ERR), 32'd0);
        @(posedge CLK);
        #1;
        dbg_check("nop_r3", 2'd3, 8'hFE);

        // Reset during WB of ADD r2 aborts the write
        send(4'd2, 2'd2, 2'd3, 2'd0, 8'h00);
        @(posedge CLK);
        #1;
        check("abort_wb_done", 32'(DONE), 32'd1);
        RST = 1'b1;
        #1;
        check("abort_ready_in_rst", 32'(INSTR_READY), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_flags", 32'(FLAGS), 32'd0);
        dbg_check("abort_r2", 2'd2, 8'h00);
        @(posedge CLK);
        #1;
        check("abort_done_later", 32'(DONE), 32'd0);

        // Back-to-back ALU stream with VALID held high
        do_ldi(2'd0, 8'h01);
        do_ldi(2'd1, 8'h02);
        s_op = '{4'd2, 4'd3, 4'd6};
        s_rd = '{2'd2, 2'd3, 2'd0};
        s_rs = '{2'd0, 2'd2, 2'd3};
        s_rt = '{2'd1, 2'd0, 2'd1};
        idx   = 0;
        ndone = 0;
        cyc   = 0;
        INSTR_OP    = s_op[0];
        INSTR_RD    = s_rd[0];
        INSTR_RS    = s_rs[0];
        INSTR_RT    = s_rt[0];
        INSTR_VALID = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ready_before = INSTR_READY;
            @(posedge CLK);
            #1;
            cyc++;
            if (ready_before && INSTR_VALID) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 3) begin
                    INSTR_OP = s_op[idx];
                    INSTR_RD = s_rd[idx];
                    INSTR_RS = s_rs[idx];
                    INSTR_RT = s_rt[idx];
                end else begin
                    INSTR_VALID = 1'b0;
                end
            end
            if (DONE && (ndone < 3)) begin
                got_addr[ndone] = WB_ADDR;
                got_data[ndone] = WB_DATA;
                ndone++;
            end
        end
        INSTR_VALID = 1'b0;
        check("stream_accepts", 32'(idx), 32'd3);
        check("stream_dones", 32'(ndone), 32'd3);
        if ((idx == 3) && (ndone == 3)) begin
            check("stream_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("stream_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("stream_res0", {22'd0, got_addr[0], got_data[0]}, {22'd0, 2'd2, 8'h03});
            check("stream_res1", {22'd0, got_addr[1], got_data[1]}, {22'd0, 2'd3, 8'h02});
            check("stream_res2", {22'd0, got_addr[2], got_data[2]}, {22'd0, 2'd0, 8'h00});
        end
        check("stream_flags", 32'(FLAGS), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
